// File: rtl/irq_request_latch.sv
// Request-capture stage ahead of an external 8-to-3 priority encoder.
// Latches request lines into a pending register and presents them one at a time on a valid/ack handshake.
module irq_request_latch #(
  parameter bit EDGE_MODE = 1'b1,
  localparam int unsigned N_LINES = 8,
  localparam int unsigned IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] req_in,
  input  logic [N_LINES-1:0] mask_in,
  output logic [N_LINES-1:0] pend_out,
  input  logic [IDX_W-1:0]   enc_idx,
  output logic               irq_valid,
  output logic [IDX_W-1:0]   irq_id,
  input  logic               irq_ack,
  output logic [N_LINES-1:0] ovf_flag,
  input  logic               ovf_clr
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [N_LINES-1:0]   pend_raw_q, pend_raw_d;
  logic [N_LINES-1:0]   req_d_q, req_d_d;
  logic [N_LINES-1:0]   ovf_flag_q, ovf_flag_d;
  logic [IDX_W-1:0]     irq_id_q, irq_id_d;
  logic                 irq_valid_q, irq_valid_d;

  logic [N_LINES-1:0]   set_vec;
  logic [N_LINES-1:0]   clr_vec;
  logic [N_LINES-1:0]   ovf_set;
  logic                 ack_accept;

  // Pending capture and overflow tracking; a new set on a bit wins over its clear.
  always_comb begin
    set_vec    = EDGE_MODE ? (req_in & ~req_d_q) : req_in;
    ack_accept = (state_q == PRESENT) && irq_ack;
    clr_vec    = ack_accept ? (N_LINES'(1) << irq_id_q) : '0;
    pend_raw_d = (pend_raw_q & ~clr_vec) | set_vec;
    req_d_d    = req_in;
    ovf_set    = EDGE_MODE ? (set_vec & pend_raw_q & ~clr_vec) : '0;
    ovf_flag_d = (ovf_clr ? '0 : ovf_flag_q) | ovf_set;
  end

  // Presentation FSM: the index is frozen for the whole grant, whatever the encoder does meanwhile.
  always_comb begin
    state_d     = state_q;
    irq_id_d    = irq_id_q;
    irq_valid_d = irq_valid_q;
    unique case (state_q)
      IDLE: begin
        if (pend_out != '0) begin
          irq_id_d    = enc_idx;
          irq_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          irq_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        irq_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // req_d resets to all-ones so lines already high at reset release do not count as edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_raw_q  <= '0;
      req_d_q     <= '1;
      ovf_flag_q  <= '0;
      irq_id_q    <= '0;
      irq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_raw_q  <= pend_raw_d;
      req_d_q     <= req_d_d;
      ovf_flag_q  <= ovf_flag_d;
      irq_id_q    <= irq_id_d;
      irq_valid_q <= irq_valid_d;
    end
  end

  assign pend_out  = pend_raw_q & mask_in;
  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign ovf_flag  = ovf_flag_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Bench for irq_request_latch: directed vector table, hand-written corner sequences,
// then random traffic against a per-line behavioural model for both edge and level modes.
module tb_irq_request_latch;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask_in;
  logic       irq_ack;
  logic       ovf_clr;

  logic [7:0] pend_e, ovf_e, pend_l, ovf_l;
  logic [2:0] enc_e, id_e, enc_l, id_l;
  logic       valid_e, valid_l;

  int checks   = 0;
  int failures = 0;

  // Stand-in for the downstream encoder: highest set bit wins.
  function automatic logic [2:0] prio(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  assign enc_e = prio(pend_e);
  assign enc_l = prio(pend_l);

  irq_request_latch #(.EDGE_MODE(1'b1)) dut_e (
    .clk(clk), .rst(rst), .req_in(req_in), .mask_in(mask_in),
    .pend_out(pend_e), .enc_idx(enc_e), .irq_valid(valid_e), .irq_id(id_e),
    .irq_ack(irq_ack), .ovf_flag(ovf_e), .ovf_clr(ovf_clr)
  );

  irq_request_latch #(.EDGE_MODE(1'b0)) dut_l (
    .clk(clk), .rst(rst), .req_in(req_in), .mask_in(mask_in),
    .pend_out(pend_l), .enc_idx(enc_l), .irq_valid(valid_l), .irq_id(id_l),
    .irq_ack(irq_ack), .ovf_flag(ovf_l), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pend;
    logic [7:0] prev;
    logic [7:0] ovf;
    logic       valid;
    logic [2:0] id;
  } mstate_t;

  mstate_t m_e, m_l;
  bit      model_ok = 1'b0;

  // One clock of the reference behaviour, worked line by line.
  function automatic mstate_t mstep(input mstate_t s, input bit edge_mode, input logic r,
                                    input logic [7:0] req, input logic [7:0] mask,
                                    input logic ack, input logic oclr);
    mstate_t n;
    bit accepted, fire, served;
    logic [7:0] vis;
    n = s;
    if (r) begin
      n.pend = 8'h00; n.prev = 8'hFF; n.ovf = 8'h00; n.valid = 1'b0; n.id = 3'd0;
      return n;
    end
    accepted = s.valid && ack;
    for (int i = 0; i < 8; i++) begin
      fire   = edge_mode ? (req[i] && !s.prev[i]) : req[i];
      served = accepted && (s.id == 3'(i));
      n.pend[i] = fire || (s.pend[i] && !served);
      n.ovf[i]  = (edge_mode && fire && s.pend[i] && !served) || (s.ovf[i] && !oclr);
    end
    if (!s.valid) begin
      vis = s.pend & mask;
      if (vis != 8'h00) begin
        n.valid = 1'b1;
        n.id    = prio(vis);
      end
    end else if (ack) begin
      n.valid = 1'b0;
    end
    n.prev = req;
    return n;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance one clock, update the models with the inputs seen at that edge, compare after the edge.
  task automatic step();
    @(posedge clk);
    m_e = mstep(m_e, 1'b1, rst, req_in, mask_in, irq_ack, ovf_clr);
    m_l = mstep(m_l, 1'b0, rst, req_in, mask_in, irq_ack, ovf_clr);
    if (rst) model_ok = 1'b1;
    #1;
    if (model_ok) begin
      check("model_e_pend",  pend_e,  m_e.pend & mask_in);
      check("model_e_valid", 8'(valid_e), 8'(m_e.valid));
      check("model_e_id",    8'(id_e),    8'(m_e.id));
      check("model_e_ovf",   ovf_e,   m_e.ovf);
      check("model_l_pend",  pend_l,  m_l.pend & mask_in);
      check("model_l_valid", 8'(valid_l), 8'(m_l.valid));
      check("model_l_id",    8'(id_l),    8'(m_l.id));
      check("model_l_ovf",   ovf_l,   m_l.ovf);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       oclr;
    logic [7:0] e_pend;
    logic       e_valid;
    logic [2:0] e_id;
    logic [7:0] e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [7:0] req, input logic [7:0] mask,
                              input logic ack, input logic oclr, input logic [7:0] pend,
                              input logic valid, input logic [2:0] id, input logic [7:0] ovf);
    vec_t v;
    v.rst = r; v.req = req; v.mask = mask; v.ack = ack; v.oclr = oclr;
    v.e_pend = pend; v.e_valid = valid; v.e_id = id; v.e_ovf = ovf;
    vecs.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; req_in = 8'h00; mask_in = 8'hFF; irq_ack = 1'b0; ovf_clr = 1'b0;
    m_e = '{default: '0}; m_l = '{default: '0};

    // Expected edge-mode outputs after each edge:        pend  vld id  ovf
    add(1, 8'h00, 8'hFF, 0, 0,                          8'h00, 0, 0, 8'h00);
    add(0, 8'h00, 8'hFF, 0, 0,                          8'h00, 0, 0, 8'h00);
    add(0, 8'hCC, 8'hFF, 0, 0,                          8'hCC, 0, 0, 8'h00);
    add(0, 8'h00, 8'hFF, 0, 0,                          8'hCC, 1, 7, 8'h00);
    add(0, 8'h00, 8'hFF, 1, 0,                          8'h4C, 0, 7, 8'h00);
    add(0, 8'h00, 8'hFF, 0, 0,                          8'h4C, 1, 6, 8'h00);
    add(0, 8'h00, 8'hFF, 1, 0,                          8'h0C, 0, 6, 8'h00);
    add(0, 8'h00, 8'hFF, 0, 0,                          8'h0C, 1, 3, 8'h00);
    add(0, 8'h00, 8'hFF, 1, 0,                          8'h04, 0, 3, 8'h00);
    add(0, 8'h00, 8'hFF, 0, 0,                          8'h04, 1, 2, 8'h00);
    add(0, 8'h00, 8'hFF, 1, 0,                          8'h00, 0, 2, 8'h00);
    add(0, 8'h00, 8'hFF, 0, 0,                          8'h00, 0, 2, 8'h00);
    // masked line 7 stays held until unmasked
    add(0, 8'h81, 8'h0F, 0, 0,                          8'h01, 0, 2, 8'h00);
    add(0, 8'h00, 8'h0F, 0, 0,                          8'h01, 1, 0, 8'h00);
    add(0, 8'h00, 8'h0F, 1, 0,                          8'h00, 0, 0, 8'h00);
    add(0, 8'h00, 8'h0F, 0, 0,                          8'h00, 0, 0, 8'h00);
    add(0, 8'h00, 8'hFF, 0, 0,                          8'h80, 1, 7, 8'h00);
    add(0, 8'h00, 8'hFF, 1, 0,                          8'h00, 0, 7, 8'h00);
    // overflow on line 5 while presented, then cleared
    add(0, 8'h20, 8'hFF, 0, 0,                          8'h20, 0, 7, 8'h00);
    add(0, 8'h00, 8'hFF, 0, 0,                          8'h20, 1, 5, 8'h00);
    add(0, 8'h20, 8'hFF, 0, 0,                          8'h20, 1, 5, 8'h20);
    add(0, 8'h00, 8'hFF, 0, 1,                          8'h20, 1, 5, 8'h00);
    add(0, 8'h00, 8'hFF, 1, 0,                          8'h00, 0, 5, 8'h00);
    // new edge on line 2 during its own ack
    add(0, 8'h04, 8'hFF, 0, 0,                          8'h04, 0, 5, 8'h00);
    add(0, 8'h00, 8'hFF, 0, 0,                          8'h04, 1, 2, 8'h00);
    add(0, 8'h04, 8'hFF, 1, 0,                          8'h04, 0, 2, 8'h00);
    add(0, 8'h00, 8'hFF, 0, 0,                          8'h04, 1, 2, 8'h00);
    add(0, 8'h00, 8'hFF, 1, 0,                          8'h00, 0, 2, 8'h00);
    // reset while presenting with three lines pending and an overflow set
    add(0, 8'h13, 8'hFF, 0, 0,                          8'h13, 0, 2, 8'h00);
    add(0, 8'h00, 8'hFF, 0, 0,                          8'h13, 1, 4, 8'h00);
    add(0, 8'h10, 8'hFF, 0, 0,                          8'h13, 1, 4, 8'h10);
    add(1, 8'h00, 8'hFF, 0, 0,                          8'h00, 0, 0, 8'h00);
    add(0, 8'h00, 8'hFF, 1, 0,                          8'h00, 0, 0, 8'h00);
    add(0, 8'h00, 8'hFF, 0, 0,                          8'h00, 0, 0, 8'h00);

    foreach (vecs[k]) begin
      rst = vecs[k].rst; req_in = vecs[k].req; mask_in = vecs[k].mask;
      irq_ack = vecs[k].ack; ovf_clr = vecs[k].oclr;
      step();
      check($sformatf("vec%0d_pend", k),  pend_e,       vecs[k].e_pend);
      check($sformatf("vec%0d_valid", k), 8'(valid_e),  8'(vecs[k].e_valid));
      check($sformatf("vec%0d_id", k),    8'(id_e),     8'(vecs[k].e_id));
      check($sformatf("vec%0d_ovf", k),   ovf_e,        vecs[k].e_ovf);
    end

    // Line 4 held high through reset release: ignored in edge mode, fires in level mode.
    irq_ack = 1'b0; ovf_clr = 1'b0; mask_in = 8'hFF;
    rst = 1'b1; req_in = 8'h10;
    step();
    rst = 1'b0;
    step();
    check("held_e_pend1",  pend_e, 8'h00);
    check("held_e_valid1", 8'(valid_e), 8'h00);
    check("held_l_pend1",  pend_l, 8'h10);
    check("held_l_valid1", 8'(valid_l), 8'h00);
    step();
    check("held_e_pend2",  pend_e, 8'h00);
    check("held_e_valid2", 8'(valid_e), 8'h00);
    check("held_l_valid2", 8'(valid_l), 8'h01);
    check("held_l_id2",    8'(id_l), 8'h04);
    check("held_l_ovf2",   ovf_l, 8'h00);
    req_in = 8'h00; irq_ack = 1'b1;
    step();
    check("held_l_valid3", 8'(valid_l), 8'h00);
    check("held_l_pend3",  pend_l, 8'h00);
    irq_ack = 1'b0;
    step();

    // Random traffic against the models.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 63) == 0);
      req_in  = 8'($urandom) & 8'($urandom);
      mask_in = ($urandom_range(0, 9) < 7) ? 8'hFF : 8'($urandom);
      irq_ack = 1'($urandom);
      ovf_clr = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
